// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR addresses, mstatus bit positions and trap FSM states
// shared by the interrupt/trap controller.
package riscv_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Interrupt line i reports as cause (IRQ_CAUSE_BASE + i) and lives at mie/mip bit 16+i.
  localparam int IRQ_CAUSE_BASE = 16;

  typedef enum logic {ST_IDLE, ST_FLUSH} trap_state_e;
endpackage

// File: rtl/irq_trap_ctrl_if.sv
// Core <-> trap controller signal bundle; the core side is master,
// the controller is slave.
interface irq_trap_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int N_IRQ = 4
);
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_ack;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic             mret;
  logic             csr_we;
  logic             csr_re;
  logic [11:0]      csr_addr;
  logic [XLEN-1:0]  csr_wdata;
  logic [XLEN-1:0]  csr_rdata;
  logic             csr_illegal;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             in_trap;

  modport master (
    output irq_in, retire_valid, retire_pc, mret, csr_we, csr_re, csr_addr, csr_wdata,
    input  irq_ack, csr_rdata, csr_illegal, redirect_valid, redirect_pc, flush, in_trap
  );
  modport slave (
    input  irq_in, retire_valid, retire_pc, mret, csr_we, csr_re, csr_addr, csr_wdata,
    output irq_ack, csr_rdata, csr_illegal, redirect_valid, redirect_pc, flush, in_trap
  );
endinterface

// File: rtl/irq_sync.sv
// N-bit two-flop synchroniser with asynchronous clear for raw interrupt lines.
module irq_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap controller: CSR file, lowest-index interrupt
// arbitration, direct/vectored trap entry, mret return and post-redirect flush.
module irq_trap_ctrl
  import riscv_csr_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              N_IRQ        = 4,
  parameter int              FLUSH_CYCLES = 1,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0
) (
  input logic            clk,
  input logic            reset,
  irq_trap_ctrl_if.slave bus
);
  localparam int              CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [XLEN-1:0] LO2 = XLEN'(3);
  localparam logic [XLEN-1:0] MSB = {1'b1, {(XLEN-1){1'b0}}};

  trap_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [N_IRQ-1:0] mip, mie_q, pend, ack_d, irq_ack_q;
  logic             mstatus_mie_q, mpie_q, in_trap_q, mtvec_mode_q, redirect_valid_q, flush_q;
  logic [XLEN-1:0]  mtvec_base_q, mepc_q, mcause_q, redirect_pc_q, trap_pc_d, cause_d, rdata_d;
  logic [4:0]       win;
  logic             idle, take, do_ret, wr, legal;

  irq_sync #(.W(N_IRQ)) u_sync (.clk(clk), .rst(reset), .d_i(bus.irq_in), .q_o(mip));

  assign idle   = (state_q == ST_IDLE);
  assign pend   = mip & mie_q;
  assign do_ret = idle & bus.retire_valid & bus.mret;
  assign take   = idle & bus.retire_valid & ~bus.mret & mstatus_mie_q & (|pend);
  assign wr     = idle & bus.csr_we;

  // Scan high-to-low so the lowest pending index is the last (winning) assignment.
  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (pend[i]) win = 5'(i);
  end

  assign ack_d     = N_IRQ'(1) << win;
  assign cause_d   = XLEN'(IRQ_CAUSE_BASE) + XLEN'(win);
  assign trap_pc_d = mtvec_mode_q ? mtvec_base_q + (cause_d << 2) : mtvec_base_q;

  always_comb begin
    rdata_d = '0;
    legal   = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        rdata_d[MSTATUS_MIE]                   = mstatus_mie_q;
        rdata_d[MSTATUS_MPIE]                  = mpie_q;
        rdata_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MIE:    rdata_d = XLEN'(mie_q) << IRQ_CAUSE_BASE;
      CSR_MTVEC:  rdata_d = mtvec_base_q | XLEN'(mtvec_mode_q);
      CSR_MEPC:   rdata_d = mepc_q;
      CSR_MCAUSE: rdata_d = mcause_q;
      CSR_MIP:    rdata_d = XLEN'(mip) << IRQ_CAUSE_BASE;
      default:    legal   = 1'b0;
    endcase
  end

  assign bus.csr_rdata      = rdata_d;
  assign bus.csr_illegal    = (bus.csr_we | bus.csr_re) & ~legal;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.irq_ack        = irq_ack_q;
  assign bus.in_trap        = in_trap_q;

  // CSR writes come first so trap/mret updates below override them on the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      mie_q            <= '0;
      mstatus_mie_q    <= 1'b0;
      mpie_q           <= 1'b0;
      mtvec_base_q     <= MTVEC_RESET & ~LO2;
      mtvec_mode_q     <= (MTVEC_RESET[1:0] == 2'd1);
      mepc_q           <= '0;
      mcause_q         <= '0;
      in_trap_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      irq_ack_q        <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      irq_ack_q        <= '0;
      if (wr) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_q <= bus.csr_wdata[MSTATUS_MIE];
            mpie_q        <= bus.csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:    mie_q <= bus.csr_wdata[IRQ_CAUSE_BASE +: N_IRQ];
          CSR_MTVEC: begin
            mtvec_base_q <= bus.csr_wdata & ~LO2;
            mtvec_mode_q <= (bus.csr_wdata[1:0] == 2'd1);
          end
          CSR_MEPC:   mepc_q   <= bus.csr_wdata & ~LO2;
          CSR_MCAUSE: mcause_q <= bus.csr_wdata;
          default: ;
        endcase
      end
      case (state_q)
        ST_IDLE: begin
          if (do_ret) begin
            mstatus_mie_q    <= mpie_q;
            mpie_q           <= 1'b1;
            in_trap_q        <= 1'b0;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= mepc_q;
            state_q          <= ST_FLUSH;
            flush_q          <= 1'b1;
            cnt_q            <= CW'(FLUSH_CYCLES - 1);
          end else if (take) begin
            mepc_q           <= bus.retire_pc & ~LO2;
            mcause_q         <= cause_d | MSB;
            mpie_q           <= mstatus_mie_q;
            mstatus_mie_q    <= 1'b0;
            in_trap_q        <= 1'b1;
            irq_ack_q        <= ack_d;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= trap_pc_d;
            state_q          <= ST_FLUSH;
            flush_q          <= 1'b1;
            cnt_q            <= CW'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed test-plan walk followed by a randomized phase, each cycle checked
// against a behavioural model of the machine-mode trap rules.
module tb_irq_trap_ctrl;
  localparam int XLEN = 64;
  localparam int N_IRQ = 4;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_trap_ctrl_if #(.XLEN(XLEN), .N_IRQ(N_IRQ)) bus ();
  irq_trap_ctrl #(.XLEN(XLEN), .N_IRQ(N_IRQ), .FLUSH_CYCLES(FC), .MTVEC_RESET(64'h0))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  bit        m_mie, m_mpie, m_in_trap, e_rv;
  bit [3:0]  m_en, s1, s2, e_ack;
  bit [63:0] m_mtvec, m_mepc, m_mcause, e_pc;
  int        m_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_in_trap = 0; e_rv = 0;
    m_en = 0; s1 = 0; s2 = 0; e_ack = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; e_pc = 0; m_left = 0;
  endtask

  function automatic bit [63:0] m_read(input bit [11:0] a, output bit legal);
    legal = 1;
    case (a)
      12'h300: return (64'(m_mie) << 3) | (64'(m_mpie) << 7) | 64'h1800;
      12'h304: return 64'(m_en) << 16;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 64'(s2) << 16;
      default: begin legal = 0; return 64'h0; end
    endcase
  endfunction

  // Apply the rules for the coming clock edge using the inputs currently driven.
  task automatic model_edge();
    bit idle, ret, tk;
    bit [3:0] pend;
    bit [63:0] old_mepc, old_mtvec, base;
    int w;
    if (reset) begin m_reset(); return; end
    idle = (m_left == 0);
    pend = s2 & m_en;
    ret  = idle && bus.retire_valid && bus.mret;
    tk   = idle && bus.retire_valid && !bus.mret && m_mie && (pend != 0);
    w = 0;
    while (tk && !pend[w]) w++;
    old_mepc = m_mepc;
    old_mtvec = m_mtvec;
    e_rv = 0; e_ack = 0;
    if (m_left > 0) m_left--;
    if (bus.csr_we && idle) begin
      case (bus.csr_addr)
        12'h300: if (!tk && !ret) begin m_mie = bus.csr_wdata[3]; m_mpie = bus.csr_wdata[7]; end
        12'h304: m_en = bus.csr_wdata[19:16];
        12'h305: m_mtvec = (bus.csr_wdata & ~64'h3) | ((bus.csr_wdata[1:0] == 2'd1) ? 64'd1 : 64'd0);
        12'h341: if (!tk) m_mepc = bus.csr_wdata & ~64'h3;
        12'h342: if (!tk) m_mcause = bus.csr_wdata;
        default: ;
      endcase
    end
    if (ret) begin
      m_mie = m_mpie; m_mpie = 1; m_in_trap = 0;
      e_rv = 1; e_pc = old_mepc; m_left = FC;
    end
    if (tk) begin
      m_mepc = bus.retire_pc & ~64'h3;
      m_mcause = 64'h8000_0000_0000_0000 | 64'(16 + w);
      m_mpie = m_mie; m_mie = 0; m_in_trap = 1;
      e_ack = 4'(1 << w); e_rv = 1;
      base = old_mtvec & ~64'h3;
      e_pc = old_mtvec[0] ? base + 64'(4 * (16 + w)) : base;
      m_left = FC;
    end
    s2 = s1;
    s1 = bus.irq_in;
  endtask

  task automatic check_all();
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(e_rv));
    chk("redirect_pc", bus.redirect_pc, e_pc);
    chk("flush", 64'(bus.flush), 64'(m_left > 0));
    chk("irq_ack", 64'(bus.irq_ack), 64'(e_ack));
    chk("in_trap", 64'(bus.in_trap), 64'(m_in_trap));
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic wr(input bit [11:0] a, input bit [63:0] d);
    bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = d;
    cyc();
    bus.csr_we = 0;
  endtask

  task automatic rd(input bit [11:0] a);
    bit legal;
    bit [63:0] v;
    bus.csr_re = 1; bus.csr_addr = a; #1;
    v = m_read(a, legal);
    chk("rd.rdata", bus.csr_rdata, v);
    chk("rd.illegal", 64'(bus.csr_illegal), 64'(!legal));
    bus.csr_re = 0; #1;
  endtask

  task automatic rdk(input bit [11:0] a, input bit [63:0] exp, input bit ill, input string tag);
    bus.csr_re = 1; bus.csr_addr = a; #1;
    chk({tag, ".rdata"}, bus.csr_rdata, exp);
    chk({tag, ".illegal"}, 64'(bus.csr_illegal), 64'(ill));
    bus.csr_re = 0; #1;
  endtask

  task automatic do_mret();
    bus.retire_valid = 1; bus.mret = 1;
    cyc();
    bus.retire_valid = 0; bus.mret = 0;
  endtask

  initial begin
    bit [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
    reset = 1;
    bus.irq_in = 0; bus.retire_valid = 0; bus.retire_pc = 0; bus.mret = 0;
    bus.csr_we = 0; bus.csr_re = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    m_reset();
    cyc(2);
    chk("reset.redirect_pc", bus.redirect_pc, 64'h0);
    reset = 0;
    rdk(12'h305, 64'h0, 0, "reset.mtvec");

    // Direct-mode trap on line 1
    wr(12'h300, 64'h8); wr(12'h304, 64'h20000); wr(12'h305, 64'h100);
    bus.irq_in = 4'b0010; cyc(2);
    bus.retire_valid = 1; bus.retire_pc = 64'h2C; cyc(); bus.retire_valid = 0;
    chk("t1.redirect_valid", 64'(bus.redirect_valid), 64'h1);
    chk("t1.redirect_pc", bus.redirect_pc, 64'h100);
    chk("t1.irq_ack", 64'(bus.irq_ack), 64'h2);
    rdk(12'h341, 64'h2C, 0, "t1.mepc");
    rdk(12'h342, 64'h8000_0000_0000_0011, 0, "t1.mcause");
    rdk(12'h300, 64'h1880, 0, "t1.mstatus");
    bus.irq_in = 0; cyc(3);
    do_mret();
    chk("t1.mret_pc", bus.redirect_pc, 64'h2C);
    cyc(3);

    // Vectored-mode trap on line 1
    wr(12'h305, 64'h101);
    bus.irq_in = 4'b0010; cyc(2);
    bus.retire_valid = 1; bus.retire_pc = 64'h40; cyc(); bus.retire_valid = 0;
    chk("t2.redirect_pc", bus.redirect_pc, 64'h144);
    bus.irq_in = 0; cyc(3); do_mret(); cyc(3);

    // Priority: lines 0 and 3 together
    wr(12'h304, 64'h90000);
    bus.irq_in = 4'b1001; cyc(2);
    bus.retire_valid = 1; bus.retire_pc = 64'h80; cyc(); bus.retire_valid = 0;
    chk("t3.irq_ack", 64'(bus.irq_ack), 64'h1);
    chk("t3.redirect_pc", bus.redirect_pc, 64'h140);
    bus.irq_in = 4'b1000; cyc(3);
    do_mret();
    chk("t3.mret_pc", bus.redirect_pc, 64'h80);
    cyc(3);
    bus.retire_valid = 1; bus.retire_pc = 64'h90; cyc(); bus.retire_valid = 0;
    chk("t3.irq_ack3", 64'(bus.irq_ack), 64'h8);
    chk("t3.redirect_pc3", bus.redirect_pc, 64'h14C);
    rdk(12'h342, 64'h8000_0000_0000_0013, 0, "t3.mcause");
    cyc(3);

    // mret with line 3 still pending; retire held through the flush
    bus.retire_valid = 1; bus.mret = 1; cyc();
    chk("t4.mret_pc", bus.redirect_pc, 64'h90);
    chk("t4.mret_valid", 64'(bus.redirect_valid), 64'h1);
    bus.mret = 0; bus.retire_pc = 64'h94;
    rdk(12'h300, 64'h1888, 0, "t4.mstatus");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4.flush_ignore", 64'(bus.redirect_valid), 64'h0);
      chk("t4.flush_len", 64'(bus.flush), 64'(i < 2));
    end
    cyc();
    chk("t4.retrap_ack", 64'(bus.irq_ack), 64'h8);
    bus.retire_valid = 0;
    rdk(12'h341, 64'h94, 0, "t4.mepc");
    bus.irq_in = 0; cyc(3); do_mret(); cyc(3);

    // CSR legality and masked interrupts
    wr(12'h305, 64'h203);
    rdk(12'h305, 64'h200, 0, "t5.mtvec");
    rdk(12'h7C0, 64'h0, 1, "t5.illegal");
    wr(12'h7C0, 64'hFF);
    wr(12'h300, 64'h0);
    bus.irq_in = 4'b0001; wr(12'h304, 64'h10000); cyc(2);
    bus.retire_valid = 1; bus.retire_pc = 64'h100; cyc(); bus.retire_valid = 0;
    chk("t5.masked", 64'(bus.redirect_valid), 64'h0);

    // Reset during flush
    wr(12'h300, 64'h8);
    bus.retire_valid = 1; cyc(); bus.retire_valid = 0;
    chk("t6.redirect_pc", bus.redirect_pc, 64'h200);
    cyc();
    reset = 1; #1;
    m_reset();
    check_all();
    chk("t6.flush_async", 64'(bus.flush), 64'h0);
    chk("t6.pc_async", bus.redirect_pc, 64'h0);
    cyc(2);
    reset = 0; bus.irq_in = 0;
    rdk(12'h300, 64'h1800, 0, "t6.mstatus");
    cyc(4);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) bus.irq_in = 4'($urandom);
      if ($urandom_range(3) == 0) rd(addrs[$urandom_range(6)]);
      bus.retire_valid = ($urandom_range(2) == 0);
      bus.mret = bus.retire_valid && ($urandom_range(2) == 0);
      bus.retire_pc = {$urandom, $urandom};
      bus.csr_we = ($urandom_range(3) == 0);
      bus.csr_addr = addrs[$urandom_range(6)];
      bus.csr_wdata = {$urandom, $urandom};
      if (bus.csr_addr == 12'h300 && $urandom_range(3) != 0) bus.csr_wdata[3] = 1'b1;
      cyc();
    end
    bus.csr_we = 0; bus.retire_valid = 0; bus.mret = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_trap_ctrl.md
# irq_trap_ctrl

Parametrised machine-mode interrupt and trap controller for the riscv64 core. It replaces the core's hard-wired single-vector interrupt jump and its fixed-address return with N level-sensitive interrupt lines, mie/mip/mstatus/mtvec/mepc/mcause CSRs, direct or vectored trap entry, and mret return. It sits beside the execute stage, which consumes its redirect/flush outputs and serves its CSR port.

## Interface
- XLEN, 64, data and PC width
- N_IRQ, 4, interrupt lines, 1..16
- FLUSH_CYCLES, 1, cycles flush stays high after a redirect, 1..4
- MTVEC_RESET, 0, mtvec reset value (mode 0)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- irq_in  in  N_IRQ  raw level interrupt lines, asynchronous to clk
- irq_ack  out  N_IRQ  one-hot, one-cycle pulse to the source whose trap was taken
- retire_valid  in  1  core is at an instruction boundary; retire_pc is valid
- retire_pc  in  XLEN  PC of the next instruction to execute
- mret  in  1  core is executing mret this cycle (qualified by retire_valid)
- csr_we / csr_re  in  1 / 1  CSR write / read strobes
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  write data
- csr_rdata  out  XLEN  combinational read data
- csr_illegal  out  1  combinational: strobe to an unimplemented address
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into pc
- redirect_pc  out  XLEN  target PC
- flush  out  1  discard fetched/decoded instruction
- in_trap  out  1  high from trap entry until mret

## Operation
- States: IDLE, FLUSH. IDLE -> FLUSH on trap entry or mret; FLUSH counts FLUSH_CYCLES, then -> IDLE. retire_valid, mret and CSR writes are ignored in FLUSH.
- mip[16+i] = irq_in[i] after the 2-flop synchroniser; read-only, writes ignored.
- mie: bits 16..16+N_IRQ-1 writable; all others read 0.
- mstatus: MIE (bit 3) and MPIE (bit 7) writable; MPP [12:11] reads 2'b11; all others read 0.
- mtvec: BASE [XLEN-1:2] writable; MODE [1:0]: 0 direct, 1 vectored; written values 2/3 are stored as 0.
- mepc: [1:0] read 0. mcause: fully writable.
- Other addresses: csr_rdata = 0, csr_illegal = 1, no state change.
- Take condition (IDLE): retire_valid & !mret & MIE & |(mip & mie). Lowest index i wins.
- Trap entry: mepc <= retire_pc; mcause <= {1'b1, (16+i)}; MPIE <= MIE; MIE <= 0; in_trap <= 1; irq_ack[i] pulses; redirect_pc = BASE (direct) or BASE + 4*(16+i) (vectored).
- mret (IDLE, retire_valid & mret): MIE <= MPIE; MPIE <= 1; in_trap <= 0; redirect_pc = mepc.
- Same cycle: mret beats a pending interrupt, which is re-evaluated after FLUSH with the restored MIE. A trap-entry or mret update of mstatus/mepc/mcause beats a CSR write to the same register; writes to other CSRs still land.
- Level-sensitive: a line held high retraps after mret if still enabled.

## Timing
- irq_in -> mip visible: 2 clk edges.
- Take/mret decided at the edge where retire_valid is sampled. redirect_valid, redirect_pc, flush and irq_ack are registered and high in the following cycle. flush stays high FLUSH_CYCLES cycles; redirect_valid and irq_ack are high for 1 cycle only.
- CSR writes land at the edge; a read in the same cycle returns the old value.
- Reset values: all outputs 0, redirect_pc 0, mtvec MTVEC_RESET, mstatus/mie/mepc/mcause 0, state IDLE. Reset during FLUSH aborts it with no further redirect.

## Structure
- Shared package riscv_csr_pkg: CSR address constants (0x300, 0x304, 0x305, 0x341, 0x342, 0x344), bit positions for MIE/MPIE/MPP, mcause interrupt base (16), and the IDLE/FLUSH state enum.
- Sub-module irq_sync: parametrised N-bit two-flop synchroniser with asynchronous clear.

## Test plan
- N_IRQ=4, MIE=1, mie=0x20000, mtvec=0x100 direct; raise irq_in[1]; retire_valid, retire_pc=0x2C -> redirect_pc=0x100, mepc=0x2C, mcause=0x8000_0000_0000_0011, irq_ack=4'b0010, MIE=0, MPIE=1.
- Same setup but mtvec=0x101 (vectored) -> redirect_pc=0x144.
- irq_in[0] and irq_in[3] together, both enabled -> only irq_ack[0]; after mret with line 0 dropped, line 3 trap is taken at the next retire.
- mret with a pending enabled interrupt in the same cycle -> redirect_pc=mepc, MIE restored to 1, interrupt taken at the first retire after FLUSH.
- Write mtvec=0x203 -> reads 0x200; write 0x7C0 -> csr_illegal=1, csr_rdata=0; MIE=0 with irq pending -> no redirect.
- FLUSH_CYCLES=3: flush high 3 cycles, retire_valid ignored throughout; assert reset in cycle 2 -> all outputs 0 immediately, state IDLE.
